rv32i_alu: RTL and testbench

- 32-bit RV32I integer ALU used by the execute stage of the core.
- `result` and `status` are purely combinational from `a`, `b` and `operation`; they are valid within the same evaluation delta, with no clock edge needed.
- A small clocked flag register (`status_q`) captures `status` on request for consumers that need flags one cycle later, such as branch resolution.
- Operation encoding type is `alu_opcode_t` from package `rv32i_defs`.

---
 rtl/rv32i_alu.sv | 69 ++++++
 tb/tb_rv32i_alu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rv32i_alu.sv
// rv32i_alu: RV32I integer ALU with combinational result/flags and a registered flag copy.
// Shifts (SLL/SRL/SRA) are built only when ALU_SHIFT_EN is defined; otherwise they decode as reserved.
package rv32i_defs;
   typedef enum logic [3:0] {
      SUM  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      SLT  = 4'd5,
      SLTU = 4'd6,
      SLL  = 4'd7,
      SRL  = 4'd8,
      SRA  = 4'd9
   } alu_opcode_t;
endpackage

module rv32i_alu
   import rv32i_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_opcode_t      operation,
   input  logic             flags_we,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       status,
   output logic [3:0]       status_q
);
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   add;
   logic             c;
   logic             v;
   // One adder serves SUM and SUB; SUB feeds ~b with carry-in 1, so C means "no borrow".
   always_comb begin
      bx     = (operation == SUB) ? ~b : b;
      add    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, operation == SUB};
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (operation)
         SUM, SUB: begin
            result = add[WIDTH-1:0];
            c      = add[WIDTH];
            v      = (a[WIDTH-1] == bx[WIDTH-1]) && (add[WIDTH-1] != a[WIDTH-1]);
         end
         AND:  result = a & b;
         OR:   result = a | b;
         XOR:  result = a ^ b;
         SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_SHIFT_EN
         SLL:  result = a << b[4:0];
         SRL:  result = a >> b[4:0];
         SRA:  result = $signed(a) >>> b[4:0];
`endif
         default: result = '0;
      endcase
      status = {result[WIDTH-1], result == '0, c, v};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) status_q <= 4'b0000;
      else if (flags_we) status_q <= status;
   end
endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: directed and random checks of rv32i_alu against a wide-arithmetic reference model.
module tb_rv32i_alu;
   import rv32i_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   alu_opcode_t operation = SUM;
   logic        flags_we = 1'b0;
   logic [31:0] result;
   logic [3:0]  status;
   logic [3:0]  status_q;
   int          n_chk = 0;
   int          n_fail = 0;

   rv32i_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .operation(operation),
      .flags_we(flags_we), .result(result), .status(status), .status_q(status_q)
   );

   always #5 clk = ~clk;

   // Reference: 64-bit arithmetic, flags derived from range checks rather than bit tricks.
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      longint s;
      logic [31:0] r;
      logic c, v;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            s = longint'($signed(x)) + longint'($signed(y));
            r = x + y;
            c = (longint'(x) + longint'(y)) > 64'd4294967295;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            s = longint'($signed(x)) - longint'($signed(y));
            r = x - y;
            c = x >= y;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: r = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
         4'd6: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
         4'd7: r = 32'(longint'(x) * (64'sd1 << y[4:0]));
         4'd8: r = 32'(longint'(x) / (64'sd1 << y[4:0]));
         4'd9: r = 32'(longint'($signed(x)) >>> y[4:0]);
`endif
         default: r = '0;
      endcase
      return {r, r[31], r == 32'd0, c, v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      operation = alu_opcode_t'(op);
      a = x;
      b = y;
      #1;
   endtask

   task automatic dir(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic [3:0] es);
      drive(op, x, y);
      chk({tag, "_res"}, result, er);
      chk({tag, "_st"}, {28'd0, status}, {28'd0, es});
   endtask

   initial begin
      logic [35:0] m;
      logic [3:0]  held;
      logic [31:0] x, y;
      logic [3:0]  op;
      #1;
      chk("reset_status_q", {28'd0, status_q}, 32'd0);
      dir("sum_0_0", 4'd0, 32'h0, 32'h0, 32'h0, 4'b0100);
      dir("sum_ff_0", 4'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 4'b1000);
      dir("sum_carry", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
      dir("sum_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
      dir("sub_eq", 4'd1, 32'd5, 32'd5, 32'h0, 4'b0110);
      dir("sub_neg", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000);
      dir("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);
      dir("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
      dir("slt", 4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000);
      dir("sltu", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0100);
      dir("reserved", 4'd15, 32'h1234_5678, 32'h9, 32'h0, 4'b0100);
`ifdef ALU_SHIFT_EN
      dir("sra_31", 4'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 4'b1000);
      dir("sll_wrap", 4'd7, 32'h1, 32'h21, 32'h2, 4'b0000);
`else
      dir("sll_off", 4'd7, 32'h1, 32'h1, 32'h0, 4'b0100);
`endif
      for (int i = 0; i < 32; i++) begin
         x = $urandom; y = $urandom;
         drive(4'd0, x, y);
         chk("sum_rand", result, x + y);
      end
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         y = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
         if ($urandom_range(0, 9) == 0) y = x;
         drive(op, x, y);
         m = model(op, x, y);
         chk("rand_res", result, m[35:4]);
         chk("rand_st", {28'd0, status}, {28'd0, m[3:0]});
      end
      @(negedge clk);
      rst = 1'b0;
      drive(4'd0, 32'hFFFF_FFFF, 32'h0);
      flags_we = 1'b1;
      @(posedge clk); #1;
      chk("load_1000", {28'd0, status_q}, 32'h8);
      #2 rst = 1'b1;
      #1 chk("async_rst", {28'd0, status_q}, 32'd0);
      @(posedge clk); #1;
      chk("rst_blocks_we", {28'd0, status_q}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(4'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("load_0100", {28'd0, status_q}, 32'h4);
      flags_we = 1'b0;
      drive(4'd1, 32'd3, 32'd5);
      repeat (2) @(posedge clk);
      #1 chk("hold_0100", {28'd0, status_q}, 32'h4);
      held = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         op = 4'($urandom_range(0, 15));
         x = $urandom; y = $urandom;
         flags_we = 1'($urandom_range(0, 1));
         operation = alu_opcode_t'(op); a = x; b = y;
         m = model(op, x, y);
         if (flags_we) held = m[3:0];
         @(posedge clk); #1;
         chk("reg_rand", {28'd0, status_q}, {28'd0, held});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
